stream_mux_rr: RTL
==================

# stream_mux_rr

Parametrised N-channel registered stream multiplexer with valid/ready handshake on every input and on the output. Selects one channel per beat by round-robin arbitration or by an externally forced select, and optionally holds the grant for a whole packet. Sits between several independent producers and one consumer in the datapath; one output register stage gives full throughput.

## Interface
- `NCH`, 4, number of input channels (≥2).
- `WIDTH`, 8, data bits per channel.
- `CW`, $clog2(NCH), derived localparam, channel-index width; not overridable.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `sel_mode` in 1: 0 = round-robin, 1 = forced select.
- `sel` in CW: forced channel index; used only when `sel_mode`=1.
- `in_valid` in NCH: per-channel valid.
- `in_ready` out NCH: per-channel ready.
- `in_data` in NCH*WIDTH: channel i at bits [i*WIDTH +: WIDTH].
- `in_last` in NCH: per-channel end-of-packet marker.
- `out_valid` out 1: output register holds a beat.
- `out_ready` in 1: consumer accepts.
- `out_data` out WIDTH: registered beat.
- `out_last` out 1: registered `in_last` of that beat.
- `out_ch` out CW: index of the channel the beat came from.

## Operation
- Output stage can load when `load_ok = !out_valid || out_ready`.
- Grant (combinational, at most one-hot):
  - Locked: the lock channel is granted if it is valid; otherwise nothing is granted.
  - Round-robin, unlocked: scan from `ptr+1` upward, wrapping at NCH-1→0; first valid channel wins.
  - Forced, unlocked: channel `sel` is granted if `in_valid[sel]`. If `sel` ≥ NCH, nothing is granted.
- `in_ready[i] = grant[i] && load_ok`. Every other channel sees `in_ready` low.
- Input handshake on channel g (`in_valid[g] && in_ready[g]`):
  - register data, last and g into `out_data`/`out_last`/`out_ch`;
  - set `out_valid`;
  - set `ptr <= g` in either mode, so a later round-robin scan resumes after the last served channel.
- Output handshake with no new load: clear `out_valid`. The data registers keep their values.
- Simultaneous output handshake and input load: the new beat replaces the old one and `out_valid` stays high. No bubble.
- `in_valid` dropped before the handshake: the grant is re-evaluated next cycle. No state change.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_ch`=0;
  - `ptr`=NCH-1, so channel 0 has first priority after reset;
  - lock cleared.
- Latency is 1 cycle from input handshake to `out_valid`. Throughput is 1 beat/cycle while `out_ready`=1.
- `in_ready` depends combinationally on `in_valid`, `sel_mode`, `sel` and `out_ready`. It never depends on `in_data`.
- A `sel_mode` or `sel` change takes effect in the same cycle when unlocked. While locked it is ignored until unlock.
- Reset asserted mid-packet clears the lock and `out_valid` immediately. An in-flight beat is dropped.

## Configuration
- `STREAM_MUX_PKT_LOCK_EN` defined:
  - An input handshake with `in_last`=0 sets the lock to channel g.
  - An input handshake with `in_last`=1 on the locked channel clears the lock.
  - Packets from different channels never interleave on the output.
- Not defined:
  - No lock state; arbitration is per beat.
  - `in_last` is passed through to `out_last` only.

## Structure
- Package `stream_mux_pkg` holds:
  - `typedef enum logic {MODE_RR=1'b0, MODE_FORCED=1'b1} mux_mode_t`;
  - a helper function returning the round-robin winner index given a valid vector and a pointer.
- Sub-module `rr_arbiter` (params NCH, CW):
  - inputs: valid vector, pointer;
  - outputs: one-hot grant, index, any-grant.
- The top level owns the pointer, lock, forced-select path and output register.

## Test plan
- Reset, then all 4 valid with data 0xA0..0xA3, `out_ready`=1, RR mode → `out_ch` sequence 0,1,2,3,0; one beat/cycle; first `out_valid` 1 cycle after the first handshake.
- RR, channels 1 and 3 valid, `out_ready` held 0 for 3 cycles → `out_data` stable at the channel-1 beat; `in_ready` all 0 after the load; after release, next `out_ch`=3.
- Forced mode, `sel`=2, channels 0..3 valid → only channel 2 ever handshakes; `sel`=2 with `in_valid[2]`=0 → no grant; NCH=3 with `sel`=3 → no grant.
- With `STREAM_MUX_PKT_LOCK_EN`: channel 1 sends 3-beat packet (`last` on beat 3) while channel 0 valid throughout → `out_ch` 1,1,1 then 0; mid-packet switch to forced `sel`=0 is ignored until beat 3.
- Without the macro, same stimulus → `out_ch` alternates 1,0,1,0…; `out_last` mirrors `in_last`.
- `rst_n` pulsed low mid-packet with `out_valid`=1 → `out_valid`=0 asynchronously; after release channel 0 wins first.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin winner helper for the stream multiplexer.
// The helper is written against a fixed maximum width so one copy serves every NCH.
package stream_mux_pkg;

    typedef enum logic {MODE_RR = 1'b0, MODE_FORCED = 1'b1} mux_mode_t;

    localparam int MAX_NCH = 32;

    // Scan from ptr+1 upward with wrap; returns -1 when no channel is valid.
    function automatic int rr_winner(input logic [MAX_NCH-1:0] valid, input int ptr, input int nch);
        int idx;
        rr_winner = -1;
        for (int k = 1; k <= MAX_NCH; k++) begin
            if (k <= nch) begin
                idx = (ptr + k) % nch;
                if (rr_winner < 0 && valid[idx]) begin
                    rr_winner = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the mux, and one consumer, plus the select controls.
// master = environment side (producers/consumer), slave = the multiplexer.
interface stream_mux_rr_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
);
    import stream_mux_pkg::*;

    localparam int CW = $clog2(NCH);

    mux_mode_t            sel_mode;
    logic [CW-1:0]        sel;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;
    logic [CW-1:0]        out_ch;

    modport master (
        output sel_mode, sel, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );

    modport slave (
        input  sel_mode, sel, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first valid channel after ptr_i wins.
// Pure logic, no state; the caller owns and advances the pointer.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic [NCH-1:0] valid_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [NCH-1:0] grant_o,
    output logic [CW-1:0]  idx_o,
    output logic           any_o
);

    logic [MAX_NCH-1:0] valid_ext;
    int                 win;

    always_comb begin
        valid_ext              = '0;
        valid_ext[NCH-1:0]     = valid_i;
        win                    = rr_winner(valid_ext, int'(ptr_i), NCH);
        grant_o                = '0;
        idx_o                  = '0;
        any_o                  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (win == i) begin
                grant_o[i] = 1'b1;
                idx_o      = CW'(i);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 registered stream mux, round-robin or forced select; STREAM_MUX_PKT_LOCK_EN holds the grant per packet.
// 1-cycle latency, 1 beat/cycle; in_ready only for the granted channel when the output register can load.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);

    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]   rr_grant;
    logic [CW-1:0]    rr_idx;
    logic             rr_any;
    logic [NCH-1:0]   grant;
    logic [CW-1:0]    grant_idx;
    logic [NCH-1:0]   hs_vec;
    logic             load_ok;
    logic             hs;
    logic             hs_last;
    logic [WIDTH-1:0] hs_data;

    logic [CW-1:0]    ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             lock_vld_q, lock_vld_d;
    logic [CW-1:0]    lock_ch_q, lock_ch_d;
`endif

    rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .valid_i (bus.in_valid),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .any_o   (rr_any)
    );

    // A held lock overrides both the round-robin and forced paths.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (bus.sel_mode == MODE_RR) begin
            if (rr_any) begin
                grant     = rr_grant;
                grant_idx = rr_idx;
            end
        end else begin
            grant_idx = bus.sel;
            for (int i = 0; i < NCH; i++) begin
                if (bus.sel == CW'(i)) grant[i] = bus.in_valid[i];
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_vld_q) begin
            grant     = '0;
            grant_idx = lock_ch_q;
            for (int i = 0; i < NCH; i++) begin
                if (lock_ch_q == CW'(i)) grant[i] = bus.in_valid[i];
            end
        end
`endif
    end

    assign load_ok      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = grant & {NCH{load_ok}};
    assign hs_vec       = bus.in_valid & bus.in_ready;
    assign hs           = |hs_vec;
    assign hs_last      = |(hs_vec & bus.in_last);

    always_comb begin
        hs_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (hs_vec[i]) hs_data = hs_data | bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (hs) begin
            out_valid_d = 1'b1;
            out_data_d  = hs_data;
            out_last_d  = hs_last;
            out_ch_d    = grant_idx;
            ptr_d       = grant_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // While locked, grant_idx is the lock channel, so a last beat here always ends the held packet.
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_ch_d  = lock_ch_q;
        if (hs) begin
            if (!hs_last) begin
                lock_vld_d = 1'b1;
                lock_ch_d  = grant_idx;
            end else if (lock_vld_q) begin
                lock_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld_q <= 1'b0;
            lock_ch_q  <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_ch_q  <= lock_ch_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= CW'(NCH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_ch    = out_ch_q;

endmodule
